axis_rr_arbiter: RTL
====================

// Module: axis_rr_arbiter
// PURPOSE
//  N-input AXI-Stream round-robin packet arbiter for the cross router. Sits directly
//  downstream of the per-port input queues and merges their outputs onto one output
//  port. Grants are packet-locked: a grant holds until the beat with TLAST is accepted.
//  The output is registered, and the winning source index is carried on m_tid.
// PARAMETERS
//  N_INPUTS    4   number of upstream queue ports (>=2)
//  DATA_WIDTH  32  TDATA width
//  DEST_WIDTH  4   TDEST width, passed through unchanged
//  SRC_WIDTH   $clog2(N_INPUTS)  width of m_tid (derived; do not override)
// PORTS
//  clk       in   1                     clock, rising edge
//  rst_n     in   1                     async active-low reset
//  s_tvalid  in   N_INPUTS              per-input TVALID
//  s_tready  out  N_INPUTS              per-input TREADY
//  s_tdata   in   N_INPUTS*DATA_WIDTH   input i data at [i*DATA_WIDTH +: DATA_WIDTH]
//  s_tlast   in   N_INPUTS              per-input TLAST
//  s_tdest   in   N_INPUTS*DEST_WIDTH   input i dest at [i*DEST_WIDTH +: DEST_WIDTH]
//  m_tvalid  out  1                     output TVALID (registered)
//  m_tready  in   1                     output TREADY
//  m_tdata   out  DATA_WIDTH            output data (registered)
//  m_tlast   out  1                     output TLAST (registered)
//  m_tdest   out  DEST_WIDTH            output dest (registered)
//  m_tid     out  SRC_WIDTH             index of the input that sourced the beat
// BEHAVIOUR
//  Reset (async, rst_n=0), all forced immediately:
//   - state=IDLE, grant=0, rr_ptr=0.
//   - s_tready=0, m_tvalid=0, m_tdata/m_tlast/m_tdest/m_tid=0.
//   - A packet in flight at reset is dropped; there is no partial-packet recovery.
//  FSM IDLE:
//   - s_tready all 0.
//   - If any s_tvalid is set, grant <= first set index searching rr_ptr, rr_ptr+1, ...
//     (mod N_INPUTS); state <= LOCKED.
//   - Otherwise stay in IDLE.
//  FSM LOCKED:
//   - s_tready[grant] = !m_tvalid || m_tready (combinational); all other s_tready=0.
//   - Beat accepted (s_tvalid[grant] && s_tready[grant]): output register loads
//     data/last/dest of input grant, m_tid <= grant, m_tvalid <= 1.
//   - If the accepted beat has s_tlast=1: state <= IDLE, rr_ptr <= (grant+1) mod N_INPUTS.
//  Output register:
//   - If m_tvalid && m_tready and no new beat is loaded that cycle: m_tvalid <= 0.
//   - If m_tvalid && !m_tready: m_tdata/m_tlast/m_tdest/m_tid/m_tvalid held stable.
//   - Simultaneous drain and load: new beat replaces the old; m_tvalid stays 1.
//  Throughput and latency:
//   - 1 beat/cycle while locked and m_tready=1.
//   - 1 IDLE arbitration cycle between packets.
//   - s_tvalid rising in IDLE at cycle 0: grant at edge 1, first accept in cycle 1,
//     m_tvalid=1 in cycle 2.
//  Boundary conditions:
//   - Wrap-around: rr_ptr and the search index wrap modulo N_INPUTS.
//   - Losing inputs are never acked; their data is ignored.
//   - The granted input dropping TVALID mid-packet keeps the lock (bubble, no re-arbitration).
//   - s_tdest is not interpreted, only passed through.
//   - A single-beat packet (TLAST on first beat) returns to IDLE after one accept.
// TESTING
//  1. Reset values: rst_n=0 -> all s_tready=0, m_tvalid=0, m_tid=0.
//     Deassert reset with no s_tvalid -> state stays IDLE.
//  2. Single input 2, 3-beat packet (A1, A2, A3 with last), m_tready=1
//     -> m_tdata A1/A2/A3 on consecutive cycles from cycle 2; m_tid=2; m_tlast only on A3.
//  3. All 4 inputs send 1-beat packets continuously
//     -> m_tid sequence 0,1,2,3,0...; one bubble cycle between packets.
//  4. Input 1 sends a 4-beat packet while input 0 is also valid
//     -> all 4 input-1 beats complete before any input-0 beat; s_tready[0] stays 0 meanwhile.
//  5. m_tready=0 for 5 cycles mid-packet
//     -> m_tdata/m_tid held stable, s_tready[grant]=0; no beat lost or duplicated on resume.
//  6. rst_n asserted mid-packet
//     -> outputs clear in the same cycle; after release, arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// N-input AXI-Stream round-robin packet arbiter with packet-locked grants and a
// registered output stage that tags each beat with its source index on m_tid.
module axis_rr_arbiter #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEST_WIDTH = 4,
    parameter int SRC_WIDTH  = $clog2(N_INPUTS)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_INPUTS-1:0]              s_tvalid,
    output logic [N_INPUTS-1:0]              s_tready,
    input  logic [N_INPUTS*DATA_WIDTH-1:0]   s_tdata,
    input  logic [N_INPUTS-1:0]              s_tlast,
    input  logic [N_INPUTS*DEST_WIDTH-1:0]   s_tdest,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [DATA_WIDTH-1:0]            m_tdata,
    output logic                             m_tlast,
    output logic [DEST_WIDTH-1:0]            m_tdest,
    output logic [SRC_WIDTH-1:0]             m_tid
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state;
    logic [SRC_WIDTH-1:0]   grant;
    logic [SRC_WIDTH-1:0]   rr_ptr;

    logic                   out_ready;
    logic                   accept;
    logic                   sel_valid;
    logic                   sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [DEST_WIDTH-1:0]  sel_dest;

    // First requester at or after ptr, searching upward with wrap-around.
    function automatic logic [SRC_WIDTH-1:0] rr_pick(
        input logic [N_INPUTS-1:0]  req,
        input logic [SRC_WIDTH-1:0] ptr
    );
        logic [SRC_WIDTH-1:0] pick;
        logic [SRC_WIDTH-1:0] idx;
        logic                 found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N_INPUTS; k++) begin
            idx = SRC_WIDTH'((int'(ptr) + k) % N_INPUTS);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [SRC_WIDTH-1:0] next_ptr(input logic [SRC_WIDTH-1:0] g);
        return (g == SRC_WIDTH'(N_INPUTS - 1)) ? '0 : g + 1'b1;
    endfunction

    assign out_ready = !m_tvalid || m_tready;
    assign accept    = (state == LOCKED) && sel_valid && out_ready;

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_dest  = '0;
        s_tready  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (grant == SRC_WIDTH'(i)) begin
                sel_valid   = s_tvalid[i];
                sel_last    = s_tlast[i];
                sel_data    = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_dest    = s_tdest[i*DEST_WIDTH +: DEST_WIDTH];
                s_tready[i] = (state == LOCKED) && out_ready;
            end
        end
    end

    // Arbitration FSM and output register; a load always wins over a drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
            m_tdest  <= '0;
            m_tid    <= '0;
        end else begin
            if (accept) begin
                m_tvalid <= 1'b1;
                m_tdata  <= sel_data;
                m_tlast  <= sel_last;
                m_tdest  <= sel_dest;
                m_tid    <= grant;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|s_tvalid) begin
                        grant <= rr_pick(s_tvalid, rr_ptr);
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && sel_last) begin
                        state  <= IDLE;
                        rr_ptr <= next_ptr(grant);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
